// File: rtl/denise_ham_pipeline_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : denise_ham_pipeline_if                                       |
// | Description : Register-write and pixel-stream bundle for the Denise        |
// |               HAM/palette colour generator.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface denise_ham_pipeline_if #(
    parameter int CW = 8
);
    logic            clk7_en;
    logic            pix_en;
    logic [8:1]      reg_address_in;
    logic [11:0]     data_in;
    logic [2:0]      bank;
    logic            loct;
    logic [7:0]      select;
    logic [7:0]      bplxor;
    logic [1:0]      ham_mode;
    logic            blank;
    logic [3*CW-1:0] rgb;
    logic            rgb_valid;

    modport master (
        output clk7_en, pix_en, reg_address_in, data_in, bank, loct,
        output select, bplxor, ham_mode, blank,
        input  rgb, rgb_valid
    );

    modport slave (
        input  clk7_en, pix_en, reg_address_in, data_in, bank, loct,
        input  select, bplxor, ham_mode, blank,
        output rgb, rgb_valid
    );
endinterface
`default_nettype wire

// File: rtl/denise_ham_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : denise_ham_pipeline                                          |
// | Description : Two-stage palette / HAM6 / HAM8 colour generator with a      |
// |               private CLUT, write-to-read bypass and pixel-enable stall.   |
// |               The HAM hold value is the output register itself.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module denise_ham_pipeline #(
    parameter int CW    = 8,
    parameter int BANKS = 8
) (
    input  wire                  clk,
    input  wire                  reset,
    denise_ham_pipeline_if.slave bus
);
    localparam int c_DEPTH = 32 * BANKS;
    localparam int c_AW    = $clog2(c_DEPTH);

    // Each entry keeps a high-nibble set and a low-nibble set (R,G,B nibbles)
    logic [11:0]     r_clut_hi [c_DEPTH];
    logic [11:0]     r_clut_lo [c_DEPTH];

    logic            w_wr;
    logic [7:0]      w_wfull;
    logic [c_AW-1:0] w_waddr;
    logic [7:0]      w_rfull;
    logic [c_AW-1:0] w_raddr;
    logic            w_hit;
    logic [11:0]     w_rd_hi;
    logic [11:0]     w_rd_lo;

    logic [11:0]     r_s0_hi;
    logic [11:0]     r_s0_lo;
    logic [7:0]      r_s0_sel;
    logic [1:0]      r_s0_mode;
    logic            r_s0_blank;

    logic [3*CW-1:0] r_rgb;
    logic            r_valid;

    logic [CW-1:0]   w_prev_r, w_prev_g, w_prev_b;
    logic [CW-1:0]   w_pal_r, w_pal_g, w_pal_b;
    logic [CW-1:0]   w_v6;
    logic [CW-1:0]   w_nr, w_ng, w_nb;

    // 8-bit palette/HAM6 component placed at the top of a CW-bit component
    function automatic logic [CW-1:0] f_pad8(input logic [7:0] c8);
        logic [CW+7:0] t;
        t = {c8, {CW{1'b0}}};
        return t[CW+7:8];
    endfunction

    assign w_wr    = bus.clk7_en && (bus.reg_address_in[8:6] == 3'b110);
    assign w_wfull = {bus.bank, bus.reg_address_in[5:1]};
    assign w_waddr = w_wfull[c_AW-1:0];

    // Read address: mode-dependent select bits, XOR, forced to entry 0 in blanking
    always_comb begin
        w_rfull = bus.select ^ bus.bplxor;
        case (bus.ham_mode)
            2'b01:   w_rfull = {4'b0000, bus.select[3:0]} ^ bus.bplxor;
            2'b10:   w_rfull = {2'b00, bus.select[7:2]} ^ bus.bplxor;
            default: w_rfull = bus.select ^ bus.bplxor;
        endcase
        if (bus.blank) begin
            w_rfull = 8'h00;
        end
    end

    assign w_raddr = w_rfull[c_AW-1:0];

    // Same-edge write to the entry being read is forwarded, merged per loct
    assign w_hit   = w_wr && (w_waddr == w_raddr);
    assign w_rd_hi = (w_hit && !bus.loct) ? bus.data_in : r_clut_hi[w_raddr];
    assign w_rd_lo = w_hit ? bus.data_in : r_clut_lo[w_raddr];

    // CLUT write port; palette writes proceed regardless of pixel stalls
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_clut_lo[w_waddr] <= bus.data_in;
            if (!bus.loct) begin
                r_clut_hi[w_waddr] <= bus.data_in;
            end
        end
    end

    // Stage-1 colour computation from stage-0 data and the held output
    always_comb begin
        w_prev_r = r_rgb[3*CW-1:2*CW];
        w_prev_g = r_rgb[2*CW-1:CW];
        w_prev_b = r_rgb[CW-1:0];
        w_pal_r  = f_pad8({r_s0_hi[11:8], r_s0_lo[11:8]});
        w_pal_g  = f_pad8({r_s0_hi[7:4],  r_s0_lo[7:4]});
        w_pal_b  = f_pad8({r_s0_hi[3:0],  r_s0_lo[3:0]});
        w_v6     = f_pad8({r_s0_sel[3:0], r_s0_sel[3:0]});
        w_nr     = w_prev_r;
        w_ng     = w_prev_g;
        w_nb     = w_prev_b;
        if (r_s0_blank || r_s0_mode == 2'b00 || r_s0_mode == 2'b11) begin
            w_nr = w_pal_r;
            w_ng = w_pal_g;
            w_nb = w_pal_b;
        end else if (r_s0_mode == 2'b01) begin
            case (r_s0_sel[5:4])
                2'b01:   w_nb = w_v6;
                2'b10:   w_nr = w_v6;
                2'b11:   w_ng = w_v6;
                default: begin
                    w_nr = w_pal_r;
                    w_ng = w_pal_g;
                    w_nb = w_pal_b;
                end
            endcase
        end else begin
            // HAM8 replaces only the top six bits; the low bits keep their history
            case (r_s0_sel[1:0])
                2'b01:   w_nb = {r_s0_sel[7:2], w_prev_b[CW-7:0]};
                2'b10:   w_nr = {r_s0_sel[7:2], w_prev_r[CW-7:0]};
                2'b11:   w_ng = {r_s0_sel[7:2], w_prev_g[CW-7:0]};
                default: begin
                    w_nr = w_pal_r;
                    w_ng = w_pal_g;
                    w_nb = w_pal_b;
                end
            endcase
        end
    end

    // Pixel pipeline: both stages advance together on pix_en, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_hi    <= '0;
            r_s0_lo    <= '0;
            r_s0_sel   <= '0;
            r_s0_mode  <= '0;
            r_s0_blank <= 1'b1;
            r_rgb      <= '0;
            r_valid    <= 1'b0;
        end else if (bus.pix_en) begin
            r_s0_hi    <= w_rd_hi;
            r_s0_lo    <= w_rd_lo;
            r_s0_sel   <= bus.select;
            r_s0_mode  <= bus.ham_mode;
            r_s0_blank <= bus.blank;
            r_rgb      <= {w_nr, w_ng, w_nb};
            r_valid    <= ~r_s0_blank;
        end
    end

    assign bus.rgb       = r_rgb;
    assign bus.rgb_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_denise_ham_pipeline.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_denise_ham_pipeline                                       |
// | Description : Self-checking bench for denise_ham_pipeline (CW=8, BANKS=8)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_denise_ham_pipeline;
    localparam int CW    = 8;
    localparam int BANKS = 8;
    localparam int DEPTH = 32 * BANKS;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    denise_ham_pipeline_if #(.CW(CW)) bus ();

    denise_ham_pipeline #(.CW(CW), .BANKS(BANKS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural reference: palette contents, displayed colour and the one
    // pixel that has been looked up but not yet shown.
    int m_hi [DEPTH];
    int m_lo [DEPTH];
    int m_r, m_g, m_b;
    bit m_valid;
    int p_sel, p_mode, p_r, p_g, p_b;
    bit p_blank;

    function automatic logic [3*CW-1:0] model_rgb();
        return {CW'(m_r), CW'(m_g), CW'(m_b)};
    endfunction

    task automatic model_reset();
        m_r = 0; m_g = 0; m_b = 0; m_valid = 0;
        p_sel = 0; p_mode = 0; p_r = 0; p_g = 0; p_b = 0; p_blank = 1;
    endtask

    function automatic int comp8(int hi, int lo, int sh);
        return ((hi >> sh) & 15) * 16 + ((lo >> sh) & 15);
    endfunction

    task automatic model_edge();
        int ra, widx, ridx, ctl, v, sel, x, lowmask;
        ra = int'(bus.reg_address_in);
        if (bus.clk7_en && (ra / 32) == 6) begin
            widx = (int'(bus.bank) * 32 + ra % 32) % DEPTH;
            m_lo[widx] = int'(bus.data_in);
            if (!bus.loct) m_hi[widx] = int'(bus.data_in);
        end
        if (bus.pix_en) begin
            lowmask = (1 << (CW - 6)) - 1;
            if (p_blank || p_mode == 0 || p_mode == 3) begin
                m_r = p_r << (CW - 8); m_g = p_g << (CW - 8); m_b = p_b << (CW - 8);
            end else if (p_mode == 1) begin
                ctl = (p_sel / 16) % 4;
                v   = (p_sel % 16) * 17 << (CW - 8);
                if (ctl == 0) begin
                    m_r = p_r << (CW - 8); m_g = p_g << (CW - 8); m_b = p_b << (CW - 8);
                end else if (ctl == 1) m_b = v;
                else if (ctl == 2) m_r = v;
                else m_g = v;
            end else begin
                ctl = p_sel % 4;
                v   = (p_sel / 4) << (CW - 6);
                if (ctl == 0) begin
                    m_r = p_r << (CW - 8); m_g = p_g << (CW - 8); m_b = p_b << (CW - 8);
                end else if (ctl == 1) m_b = v | (m_b & lowmask);
                else if (ctl == 2) m_r = v | (m_r & lowmask);
                else m_g = v | (m_g & lowmask);
            end
            m_valid = !p_blank;
            sel = int'(bus.select);
            x   = int'(bus.bplxor);
            if (bus.blank) ridx = 0;
            else if (bus.ham_mode == 2'b01) ridx = ((sel % 16) ^ x) % DEPTH;
            else if (bus.ham_mode == 2'b10) ridx = ((sel / 4) ^ x) % DEPTH;
            else ridx = (sel ^ x) % DEPTH;
            p_sel = sel; p_mode = int'(bus.ham_mode); p_blank = bus.blank;
            p_r = comp8(m_hi[ridx], m_lo[ridx], 8);
            p_g = comp8(m_hi[ridx], m_lo[ridx], 4);
            p_b = comp8(m_hi[ridx], m_lo[ridx], 0);
        end
    endtask

    always @(posedge clk) if (!reset) model_edge();

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.clk7_en = 0; bus.pix_en = 0; bus.reg_address_in = 8'h00; bus.data_in = 12'h000;
        bus.bank = 3'd0; bus.loct = 0; bus.select = 8'h00; bus.bplxor = 8'h00;
        bus.ham_mode = 2'b00; bus.blank = 0;
    endtask

    task automatic wr(input int regaddr, input int data, input int bnk, input bit lo);
        bus.clk7_en = 1; bus.pix_en = 0;
        bus.reg_address_in = 8'(regaddr >> 1);
        bus.data_in = 12'(data); bus.bank = 3'(bnk); bus.loct = lo;
        cyc();
        bus.clk7_en = 0;
    endtask

    task automatic pix(input int sel, input int mode, input bit blk);
        bus.pix_en = 1; bus.select = 8'(sel); bus.ham_mode = 2'(mode);
        bus.blank = blk; bus.bplxor = 8'h00;
        cyc();
        bus.pix_en = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        set_idle();
        model_reset();
        #1;
        checks++;
        if (bus.rgb !== 24'h000000 || bus.rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rgb=%06h valid=%b, expected rgb=000000 valid=0", bus.rgb, bus.rgb_valid);
        end
        cyc(); cyc();
        reset = 0;
        // Put every CLUT entry in a known state (the palette is not reset)
        for (int i = 0; i < DEPTH; i++) wr(12'h180 + 2 * (i % 32), 0, i / 32, 0);
    endtask

    task automatic test_direct();
        wr(12'h180, 12'hF80, 0, 0);
        pix(8'h00, 0, 0);
        pix(8'h00, 0, 0);
        checks++;
        if (bus.rgb !== 24'hFF8800 || bus.rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL direct: rgb=%06h valid=%b, expected rgb=FF8800 valid=1", bus.rgb, bus.rgb_valid);
        end
    endtask

    task automatic test_loct();
        wr(12'h182, 12'h123, 0, 0);
        wr(12'h182, 12'h456, 0, 1);
        pix(8'h01, 0, 0);
        pix(8'h01, 0, 0);
        checks++;
        if (bus.rgb !== 24'h142536) begin
            errors++;
            $display("FAIL loct: rgb=%06h, expected 142536", bus.rgb);
        end
    endtask

    task automatic test_ham6();
        logic [7:0]  sels [4];
        logic [23:0] exps [4];
        sels = '{8'h1A, 8'h25, 8'h3F, 8'h3F};
        exps = '{24'h000000, 24'h0000AA, 24'h5500AA, 24'h55FFAA};
        wr(12'h180, 12'h000, 0, 0);
        pix(8'h00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            pix(int'(sels[i]), 1, 0);
            checks++;
            if (bus.rgb !== exps[i]) begin
                errors++;
                $display("FAIL ham6[%0d]: rgb=%06h, expected %06h", i, bus.rgb, exps[i]);
            end
        end
    endtask

    task automatic test_ham8();
        wr(12'h180, 12'h333, 0, 0);
        wr(12'h180, 12'h000, 0, 1);
        pix(8'h00, 2, 0);
        pix(8'hFD, 2, 0);
        checks++;
        if (bus.rgb !== 24'h303030) begin
            errors++;
            $display("FAIL ham8_palette: rgb=%06h, expected 303030", bus.rgb);
        end
        pix(8'hFD, 2, 0);
        checks++;
        if (bus.rgb !== 24'h3030FC) begin
            errors++;
            $display("FAIL ham8_hold: rgb=%06h, expected 3030FC", bus.rgb);
        end
    endtask

    task automatic test_blank_bypass();
        wr(12'h180, 12'h000, 0, 0);
        pix(8'h00, 1, 0);
        pix(8'h1A, 1, 0);
        pix(8'h25, 1, 0);
        pix(8'h3F, 1, 0);
        pix(8'h77, 1, 1);
        checks++;
        if (bus.rgb !== 24'h55FFAA) begin
            errors++;
            $display("FAIL blank_prev: rgb=%06h, expected 55FFAA", bus.rgb);
        end
        // Write COLOR00 and read it on the same edge
        bus.clk7_en = 1; bus.reg_address_in = 8'hC0; bus.data_in = 12'hFFF;
        bus.bank = 3'd0; bus.loct = 0;
        pix(8'h00, 0, 0);
        bus.clk7_en = 0;
        checks++;
        if (bus.rgb !== 24'h000000 || bus.rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL blank_out: rgb=%06h valid=%b, expected rgb=000000 valid=0", bus.rgb, bus.rgb_valid);
        end
        pix(8'h00, 0, 0);
        checks++;
        if (bus.rgb !== 24'hFFFFFF || bus.rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL bypass: rgb=%06h valid=%b, expected rgb=FFFFFF valid=1", bus.rgb, bus.rgb_valid);
        end
    endtask

    task automatic test_stall();
        wr(12'h180, 12'h000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.select = 8'($urandom);
            bus.ham_mode = 2'($urandom);
            cyc();
            checks++;
            if (bus.rgb !== 24'hFFFFFF || bus.rgb_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: rgb=%06h valid=%b, expected rgb=FFFFFF valid=1", i, bus.rgb, bus.rgb_valid);
            end
        end
        pix(8'h00, 0, 0);
        checks++;
        if (bus.rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL stall_resume: rgb=%06h, expected FFFFFF", bus.rgb);
        end
        pix(8'h00, 0, 0);
        checks++;
        if (bus.rgb !== 24'h000000) begin
            errors++;
            $display("FAIL stall_newread: rgb=%06h, expected 000000", bus.rgb);
        end
    endtask

    task automatic test_reset_mid();
        wr(12'h180, 12'hFFF, 0, 0);
        pix(8'h00, 0, 0);
        pix(8'h00, 0, 0);
        #2 reset = 1;
        #1;
        model_reset();
        checks++;
        if (bus.rgb !== 24'h000000 || bus.rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rgb=%06h valid=%b, expected rgb=000000 valid=0", bus.rgb, bus.rgb_valid);
        end
        @(negedge clk);
        reset = 0;
        pix(8'h1A, 1, 0);
        checks++;
        if (bus.rgb !== 24'h000000 || bus.rgb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_bubble: rgb=%06h valid=%b, expected rgb=000000 valid=0", bus.rgb, bus.rgb_valid);
        end
        pix(8'h1A, 1, 0);
        checks++;
        if (bus.rgb !== 24'h0000AA || bus.rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: rgb=%06h valid=%b, expected rgb=0000AA valid=1", bus.rgb, bus.rgb_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.clk7_en = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 3) != 0) bus.reg_address_in = 8'(8'hC0 | $urandom_range(0, 31));
            else bus.reg_address_in = 8'($urandom);
            bus.bank    = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom);
            bus.loct    = 1'($urandom);
            bus.data_in = 12'($urandom);
            bus.pix_en  = ($urandom_range(0, 99) < 70);
            bus.select  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            bus.bplxor  = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
            bus.ham_mode = 2'($urandom);
            bus.blank   = ($urandom_range(0, 99) < 10);
            cyc();
            checks++;
            if (bus.rgb !== model_rgb() || bus.rgb_valid !== m_valid) begin
                errors++;
                $display("FAIL random[%0d]: rgb=%06h valid=%b, expected rgb=%06h valid=%b",
                         i, bus.rgb, bus.rgb_valid, model_rgb(), m_valid);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_direct();
        test_loct();
        test_ham6();
        test_ham8();
        test_blank_bypass();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/denise_ham_pipeline.md
# denise_ham_pipeline

Parametrised, fully registered HAM/palette colour generator for Denise. It owns a private colour lookup table (CLUT) written through the colour register window. It converts a pixel select stream into RGB in three modes: direct palette, HAM6 or HAM8. It sits between the bitplane/priority logic and the video output stage. Unlike the previous HAM generator, the hold value lives in the output register, so there is no combinational feedback. The block also adds a pixel-enable pipeline, blanking-driven hold reset, write/read bypass, and configurable component width and bank count.

## Interface
Parameters:
- CW, 8, bits per colour component; rgb is 3*CW wide; legal values 8..10.
- BANKS, 8, palette banks of 32 entries each; power of two, 1..8; CLUT depth = 32*BANKS.

Ports:
- clk  in  1  28 MHz clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- clk7_en  in  1  7 MHz enable; qualifies register writes.
- pix_en  in  1  pixel strobe; the pipeline advances only on clk edges where pix_en=1.
- reg_address_in  in  8 ([8:1])  register address.
- data_in  in  12  register write data, 4-bit R, G, B nibbles.
- bank  in  3  palette bank for writes; only the low log2(BANKS) bits are used.
- loct  in  1  1 = write low nibbles only; 0 = write both high and low nibbles.
- select  in  8  pixel colour select.
- bplxor  in  8  CLUT read-address XOR.
- ham_mode  in  2  00 direct palette, 01 HAM6, 10 HAM8, 11 treated as 00.
- blank  in  1  pixel is outside the display window.
- rgb  out  3*CW  pixel colour {R,G,B}.
- rgb_valid  out  1  rgb holds a displayed (non-blank) pixel.

## Operation
- **Write decode:** a write occurs when clk7_en=1 and reg_address_in[8:6]=3'b110 (0x180..0x1BE).
  - Entry address = {bank, reg_address_in[5:1]}.
  - Each entry stores a 12-bit high set and a 12-bit low set.
  - loct=0: both sets are written with data_in.
  - loct=1: only the low set is written.
- **Palette colour:** 8-bit component = {hi nibble, lo nibble}.
  - It occupies the top 8 bits of the CW-bit component; the remaining CW-8 low bits are 0.
- **Read address:** (select ^ bplxor), truncated to log2(32*BANKS) bits.
  - HAM6 uses select[3:0] with the upper address bits 0, then XOR.
  - HAM8 uses {select[7:2]}, zero-extended to 8 bits, then XOR.
  - When blank=1, the read address is forced to 0.
- **Stage 0 (pix_en edge):** the CLUT is read synchronously; select, ham_mode and blank are registered alongside.
- **Stage 1 (next pix_en edge):** rgb is updated from the stage-0 data.
  - blank: rgb <= entry 0; rgb_valid <= 0. The hold value after blanking is always COLOR00.
  - Direct mode, or HAM control 00: rgb <= palette colour.
  - HAM6 control = select[5:4], value v = select[3:0]. The modified component becomes {v,v}, then zero-padded to CW bits. Control 01 = B, 10 = R, 11 = G.
  - HAM8 control = select[1:0], value v = select[7:2]. The top 6 bits of the modified component become v; its low CW-6 bits keep the previous rgb bits. Control 01 = B, 10 = R, 11 = G.
  - Non-blank pixels set rgb_valid <= 1.
  - Unmodified components always hold the previous rgb.
- **Bypass:** if a write hits the same entry that stage 0 reads on the same edge, stage 1 uses the newly written sets, merged per loct. Reads never return stale data.
- **Pipeline stall:** with pix_en=0, all pipeline and output registers hold. Palette writes still occur.

## Timing
- Reset state (asynchronous):
  - rgb = 0, rgb_valid = 0.
  - Stage-0 registers = 0, with blank = 1.
  - CLUT contents are not reset.
- Latency: select presented at pix_en edge N appears on rgb after pix_en edge N+1, i.e. 2 pix_en edges.
- A write at edge W is visible to any read sampled at edge >= W, via bypass at W.
- Reset mid-line: the first pixel after release uses prev rgb = 0 for HAM holds, unless preceded by a blank pixel.
- Mode changes take effect per pixel; the mode travels with the pixel through the pipeline.

## Test plan
- Direct mode: write 0x180 = 0xF80 with loct=0, bank=0; select=0x00, bplxor=0 → after 2 pix_en: rgb=0xFF8800 (CW=8), rgb_valid=1.
- LOCT: write 0x182 = 0x123 (loct=0), then 0x182 = 0x456 (loct=1); select=0x01 → rgb=0x142536.
- HAM6 sequence: COLOR00 = 0x000; select 0x00, 0x1A, 0x25, 0x3F → rgb 0x000000, 0x0000AA, 0x5500AA, 0x55FFAA.
- HAM8 low-bit hold: CLUT[0] written to 0x333 (loct=0), then 0x000 (loct=1), giving 0x303030; select 0x00, then 0xFD → rgb 0x303030, then 0x3030FC.
- Blank reset and bypass: prev rgb=0x55FFAA; blank=1 pixel → rgb=COLOR00, rgb_valid=0. Then, on the same edge, write 0x180 = 0xFFF and read select=0x00 → rgb=0xFFFFFF.
- Stall and reset: hold pix_en=0 for 5 clocks → rgb unchanged. Assert reset mid-stream → rgb=0 and rgb_valid=0 immediately, with no clock edge needed.
